// File: rtl/demux_1to2_sched.sv
// -----------------------------------------------------------------------------
// demux_1to2_sched
//   Upstream steering stage for a 1-to-2 demux. Takes a valid/ready stream,
//   holds one word in a pipeline register and drives the demux select (sel)
//   and data (i). A per-output valid (y0_valid / y1_valid) stays high until
//   the selected consumer is ready. The destination is either round-robin
//   (mode=0) or taken from dest (mode=1).
//
// Parameters
//   W      data width carried on in_data / i
//   CNT_W  width of the per-channel transfer counters
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid, in_data   upstream word and its valid
//   in_ready            block can accept a word this cycle (combinational)
//   mode, dest          destination policy, sampled only when a word is accepted
//   rdy0, rdy1          consumer ready for y0 / y1
//   sel, i              registered demux select and data
//   y0_valid, y1_valid  held word is destined for y0 / y1 and not yet taken
//   cnt0, cnt1          completed transfers per channel
//
// Configuration macro
//   DEMUX_SCHED_CNT_EN  when defined, cnt0/cnt1 count transfers and saturate
//                       at all-ones; when undefined they are tied to zero.
// -----------------------------------------------------------------------------
module demux_1to2_sched #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             mode,
  input  logic             dest,
  input  logic             rdy0,
  input  logic             rdy1,
  output logic             sel,
  output logic [W-1:0]     i,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         r_state;
  logic           r_sel;
  logic [W-1:0]   r_i;
  logic           r_y0_valid;
  logic           r_y1_valid;
  logic           r_rr_ptr;
  // Policy of the word currently held; rr_ptr only advances for words
  // that were accepted under round-robin.
  logic           r_mode;

  logic           w_rdy_sel;
  logic           w_xfer;
  logic           w_ready;
  logic           w_accept;
  logic           w_rr_next;

  assign w_rdy_sel = r_sel ? rdy1 : rdy0;
  assign w_xfer    = (r_state == HOLD) & w_rdy_sel;
  assign w_ready   = (r_state == IDLE) | w_xfer;
  assign w_accept  = in_valid & w_ready;
  // Post-transfer pointer; an accept in the transfer cycle uses this value,
  // which is the pre-toggle pointer inverted, so alternation stays strict.
  assign w_rr_next = r_rr_ptr ^ (w_xfer & ~r_mode);

  assign in_ready  = w_ready;
  assign sel       = r_sel;
  assign i         = r_i;
  assign y0_valid  = r_y0_valid;
  assign y1_valid  = r_y1_valid;

  // Steering FSM: loads the pipeline register and drives registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_i        <= {W{1'b0}};
      r_y0_valid <= 1'b0;
      r_y1_valid <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= HOLD;
            r_i        <= in_data;
            r_mode     <= mode;
            r_sel      <= mode ? dest : w_rr_next;
            r_y0_valid <= ~(mode ? dest : w_rr_next);
            r_y1_valid <= mode ? dest : w_rr_next;
          end else begin
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (w_accept) begin
            // Transfer and accept together: reload with no bubble.
            r_state    <= HOLD;
            r_i        <= in_data;
            r_mode     <= mode;
            r_sel      <= mode ? dest : w_rr_next;
            r_y0_valid <= ~(mode ? dest : w_rr_next);
            r_y1_valid <= mode ? dest : w_rr_next;
          end else if (w_xfer) begin
            // sel and i keep their last value on purpose.
            r_state    <= IDLE;
            r_y0_valid <= 1'b0;
            r_y1_valid <= 1'b0;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_y0_valid <= 1'b0;
          r_y1_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_SCHED_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating per-channel transfer counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_xfer && !r_sel && (r_cnt0 != CNT_MAX)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_xfer && r_sel && (r_cnt1 != CNT_MAX)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  assign cnt0 = {CNT_W{1'b0}};
  assign cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux_1to2_sched.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2_sched
//   Table-driven bench for demux_1to2_sched (W=1, CNT_W=2). Each table row
//   gives the inputs for one cycle, the expected in_ready before the edge and
//   the expected sel/i/valids after the edge. A scoreboard queue records every
//   accepted word with its expected destination and checks it when the DUT
//   hands it to a consumer. Hand-written sequences cover asynchronous reset
//   in the middle of a HOLD and counter saturation.
// -----------------------------------------------------------------------------
module tb_demux_1to2_sched;

  localparam int W     = 1;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             mode;
  logic             dest;
  logic             rdy0;
  logic             rdy1;
  logic             sel;
  logic [W-1:0]     i;
  logic             y0_valid;
  logic             y1_valid;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux_1to2_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .dest     (dest),
    .rdy0     (rdy0),
    .rdy1     (rdy1),
    .sel      (sel),
    .i        (i),
    .y0_valid (y0_valid),
    .y1_valid (y1_valid),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic vin, din, md, ds, r0, r1;
    logic e_ready, e_sel, e_i, e_y0, e_y1;
  } vec_t;

  typedef struct {
    logic dsel;
    logic data;
  } sb_t;

  vec_t vt[26];
  sb_t  sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic m_rr     = 1'b0;   // parity of round-robin accepts since reset
  int   m_cnt0   = 0;
  int   m_cnt1   = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  function automatic vec_t mk(input logic vin, din, md, ds, r0, r1,
                              input logic er, es, ei, e0, e1);
    vec_t v;
    v.vin = vin; v.din = din; v.md = md; v.ds = ds; v.r0 = r0; v.r1 = r1;
    v.e_ready = er; v.e_sel = es; v.e_i = ei; v.e_y0 = e0; v.e_y1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef DEMUX_SCHED_CNT_EN
    chk({tag, " cnt0"}, int'(cnt0), m_cnt0);
    chk({tag, " cnt1"}, int'(cnt1), m_cnt1);
`else
    chk({tag, " cnt0"}, int'(cnt0), 0);
    chk({tag, " cnt1"}, int'(cnt1), 0);
`endif
  endtask

  task automatic step(input vec_t v, input int idx);
    sb_t e;
    logic acc, xfer;
    string tag;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    in_valid = v.vin; in_data = v.din; mode = v.md; dest = v.ds;
    rdy0 = v.r0; rdy1 = v.r1;
    #1;
    chk({tag, " in_ready"}, int'(in_ready), int'(v.e_ready));
    acc  = in_valid & in_ready;
    xfer = (y0_valid & rdy0) | (y1_valid & rdy1);
    if (xfer) begin
      if (sb.size() == 0) begin
        chk({tag, " sb_nonempty"}, 0, 1);
      end else begin
        e = sb.pop_front();
        chk({tag, " sb_sel"}, int'(sel), int'(e.dsel));
        chk({tag, " sb_data"}, int'(i[0]), int'(e.data));
        if (e.dsel == 1'b0) m_cnt0 = (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
        else                m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
      end
    end
    if (acc) begin
      e.data = in_data[0];
      e.dsel = mode ? dest : m_rr;
      if (!mode) m_rr = ~m_rr;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " sel"}, int'(sel), int'(v.e_sel));
    chk({tag, " i"}, int'(i[0]), int'(v.e_i));
    chk({tag, " y0_valid"}, int'(y0_valid), int'(v.e_y0));
    chk({tag, " y1_valid"}, int'(y1_valid), int'(v.e_y1));
    chk_cnt(tag);
  endtask

  initial begin
    //             vin din md ds r0 r1 | rdy sel i y0 y1
    // round-robin, both ready: sel 0,1,0,1 back to back
    vt[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // mode=1 dest=1, y1 stalled for 5 cycles, rdy0 ignored
    vt[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // sel=0 held while only rdy1 is high
    vt[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vt[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // dest changes during HOLD are ignored until the next accept
    vt[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[16] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    // back to round-robin; pointer resumes where it was
    vt[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vt[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // after reset: 5 streamed words to y0 for counter saturation
    vt[20] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[21] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vt[22] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[23] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vt[24] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vt[25] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; dest = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset sel", int'(sel), 0);
    chk("reset i", int'(i[0]), 0);
    chk("reset y0_valid", int'(y0_valid), 0);
    chk("reset y1_valid", int'(y1_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk_cnt("reset");

    for (int k = 0; k < 20; k++) step(vt[k], k);
    chk("sb drained", sb.size(), 0);

    // Asynchronous reset while holding a word for y1.
    step(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 100);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst sel", int'(sel), 0);
    chk("arst i", int'(i[0]), 0);
    chk("arst y0_valid", int'(y0_valid), 0);
    chk("arst y1_valid", int'(y1_valid), 0);
    chk("arst cnt0", int'(cnt0), 0);
    chk("arst cnt1", int'(cnt1), 0);
    sb.delete();
    m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst in_ready", int'(in_ready), 1);
    chk("arst y1 after release", int'(y1_valid), 0);

    for (int k = 20; k < 26; k++) step(vt[k], k);
`ifdef DEMUX_SCHED_CNT_EN
    chk("sat cnt0", int'(cnt0), 3);
`else
    chk("off cnt0", int'(cnt0), 0);
`endif
    chk("sat cnt1", int'(cnt1), 0);
    chk("sb drained end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
